cpu7_dmw_xlat: RTL

- Parametrised address-translation unit that replaces the fixed one-cycle identity TLB stub on the itlb/dtlb tlb-cache interface.
- Serves NCH independent request channels, for example ch0 = instruction fetch and ch1 = data.
- Supports two modes: direct-address mode (identity mapping) and mapped mode, which uses NWIN programmable direct-mapping windows (DMW).
- Response latency is configurable; in-flight requests can be cancelled; a window miss produces a TLB-refill exception code instead of an unconditional hit.

---
 rtl/cpu7_dmw_xlat.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cpu7_dmw_xlat.sv
// Per-channel address translation for the itlb/dtlb tlb-cache interface:
// direct-address identity or DMW window mapping, LAT-deep pipeline with cancel.
module cpu7_dmw_xlat #(
   parameter int unsigned NCH    = 2,
   parameter int unsigned VABITS = 32,
   parameter int unsigned PABITS = 32,
   parameter int unsigned NWIN   = 2,
   parameter int unsigned LAT    = 1,
   parameter int unsigned SEGW   = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NCH-1:0]        tlb_req,
   input  logic [NCH*VABITS-1:0] tlb_vaddr,
   input  logic [NCH-1:0]        tlb_cancel,
   output logic [NCH-1:0]        tlb_finish,
   output logic [NCH-1:0]        tlb_hit,
   output logic [NCH*PABITS-1:0] tlb_paddr,
   output logic [NCH-1:0]        tlb_uncache,
   output logic [NCH*6-1:0]      tlb_exccode,
   input  logic                  crmd_da,
   input  logic                  crmd_datm,
   input  logic                  dmw_wen,
   input  logic [1:0]            dmw_widx,
   input  logic [2*SEGW+1:0]     dmw_wdata,
   output logic [NCH-1:0]        busy
);

   localparam logic [5:0] EXC_TLBR = 6'h3F;

   typedef struct packed {
      logic              hit;
      logic [PABITS-1:0] paddr;
      logic              uc;
      logic [5:0]        exc;
   } res_t;

   logic [NWIN-1:0] win_en_q;
   logic [NWIN-1:0] win_uc_q;
   logic [SEGW-1:0] win_vseg_q [NWIN];
   logic [SEGW-1:0] win_pseg_q [NWIN];

   logic [VABITS-1:0] va [NCH];
   res_t              xl [NCH];

   logic [LAT-1:0] vld_q [NCH];
   res_t           res_q [NCH][LAT];
   logic [LAT-1:0] vld_d [NCH];
   res_t           res_d [NCH][LAT];

   // Window registers; an index beyond NWIN matches no slot and is dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         win_en_q <= '0;
         win_uc_q <= '0;
         for (int w = 0; w < int'(NWIN); w++) begin
            win_vseg_q[w] <= '0;
            win_pseg_q[w] <= '0;
         end
      end else begin
         for (int w = 0; w < int'(NWIN); w++) begin
            if (dmw_wen && dmw_widx == 2'(w)) begin
               win_en_q[w]   <= dmw_wdata[2*SEGW+1];
               win_uc_q[w]   <= dmw_wdata[2*SEGW];
               win_vseg_q[w] <= dmw_wdata[2*SEGW-1:SEGW];
               win_pseg_q[w] <= dmw_wdata[SEGW-1:0];
            end
         end
      end
   end

   // Translation in the request cycle; descending scan lets the lowest window win.
   always_comb begin
      for (int c = 0; c < int'(NCH); c++) begin
         va[c] = tlb_vaddr[c*VABITS +: VABITS];
         xl[c] = '{hit: 1'b0, paddr: '0, uc: 1'b0, exc: EXC_TLBR};
         if (crmd_da) begin
            xl[c] = '{hit: 1'b1, paddr: va[c][PABITS-1:0], uc: crmd_datm, exc: 6'h00};
         end else begin
            for (int w = int'(NWIN) - 1; w >= 0; w--) begin
               if (win_en_q[w] && win_vseg_q[w] == va[c][VABITS-1 -: SEGW]) begin
                  xl[c] = '{hit: 1'b1,
                            paddr: {win_pseg_q[w], va[c][PABITS-SEGW-1:0]},
                            uc: win_uc_q[w], exc: 6'h00};
               end
            end
         end
      end
   end

   // Stage inputs: stage 0 takes the new request, later stages shift.
   always_comb begin
      for (int c = 0; c < int'(NCH); c++) begin
         vld_d[c]    = '0;
         vld_d[c][0] = tlb_req[c];
         res_d[c][0] = xl[c];
         for (int s = 1; s < int'(LAT); s++) begin
            vld_d[c][s] = vld_q[c][s-1];
            res_d[c][s] = res_q[c][s-1];
         end
      end
   end

   // Last stage is the output register: its result only updates on a finish.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int c = 0; c < int'(NCH); c++) begin
            vld_q[c] <= '0;
            for (int s = 0; s < int'(LAT); s++) begin
               res_q[c][s] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < int'(NCH); c++) begin
            for (int s = 0; s < int'(LAT); s++) begin
               vld_q[c][s] <= vld_d[c][s] & ~tlb_cancel[c];
               if (s != int'(LAT) - 1 || (vld_d[c][s] && !tlb_cancel[c])) begin
                  res_q[c][s] <= res_d[c][s];
               end
            end
         end
      end
   end

   // busy covers stages still ahead of the finish register.
   always_comb begin
      for (int c = 0; c < int'(NCH); c++) begin
         tlb_finish[c]              = vld_q[c][LAT-1];
         tlb_hit[c]                 = res_q[c][LAT-1].hit;
         tlb_paddr[c*PABITS +: PABITS] = res_q[c][LAT-1].paddr;
         tlb_uncache[c]             = res_q[c][LAT-1].uc;
         tlb_exccode[c*6 +: 6]      = res_q[c][LAT-1].exc;
         busy[c]                    = 1'b0;
         for (int s = 0; s < int'(LAT) - 1; s++) begin
            busy[c] = busy[c] | vld_q[c][s];
         end
      end
   end

endmodule
